// File: rtl/mips16_pkg.sv
// ---------------------------------------------------------------------------
// mips16_pkg
// Shared definitions for the 16-bit MIPS control path:
//   - 4-bit opcode encodings (OP_RTYPE .. OP_SW)
//   - 3-bit ALU operation codes handed to the ALU control stage
//   - ctrl_t: packed control word produced by the main decoder
// ---------------------------------------------------------------------------
package mips16_pkg;

   // Opcode field encodings
   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ADDI  = 4'b0001;
   localparam logic [3:0] OP_ANDI  = 4'b0010;
   localparam logic [3:0] OP_ORI   = 4'b0011;
   localparam logic [3:0] OP_NORI  = 4'b0100;
   localparam logic [3:0] OP_BEQ   = 4'b0101;
   localparam logic [3:0] OP_BNE   = 4'b0110;
   localparam logic [3:0] OP_SLTI  = 4'b0111;
   localparam logic [3:0] OP_LW    = 4'b1000;
   localparam logic [3:0] OP_SW    = 4'b1001;

   // ALU operation codes
   localparam logic [2:0] ALU_FUNCT = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_NOR   = 3'b100;
   localparam logic [2:0] ALU_BEQ   = 3'b101;
   localparam logic [2:0] ALU_BNE   = 3'b110;
   localparam logic [2:0] ALU_SLT   = 3'b111;

   // Decoded control word. The all-zero value is a harmless R-type decode
   // with no write, which is what reset and unused opcodes rely on.
   typedef struct packed {
      logic       reg_dest;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [2:0] alu_op;
      logic       illegal_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/mips16_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mips16_ctrl_decode
// Purely combinational opcode -> control-word lookup.
// Ports:
//   opcode_i : 4-bit instruction opcode
//   ctrl_o   : decoded control word (ctrl_t)
// Unused opcodes and any opcode containing X/Z fall into the default arm,
// which yields a NOP with illegal_op set.
// ---------------------------------------------------------------------------
module mips16_ctrl_decode
   import mips16_pkg::*;
(
   input  logic [3:0] opcode_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = CTRL_NOP;
      case (opcode_i)
         OP_RTYPE: begin
            ctrl_o.reg_dest  = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALU_FUNCT;
         end
         OP_ADDI: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALU_ADD;
         end
         OP_ANDI: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALU_AND;
         end
         OP_ORI: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALU_OR;
         end
         OP_NORI: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALU_NOR;
         end
         OP_BEQ: begin
            ctrl_o.branch    = 1'b1;
            ctrl_o.alu_op    = ALU_BEQ;
         end
         OP_BNE: begin
            ctrl_o.branch    = 1'b1;
            ctrl_o.alu_op    = ALU_BNE;
         end
         OP_SLTI: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALU_SLT;
         end
         OP_LW: begin
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_read   = 1'b1;
            ctrl_o.alu_op     = ALU_ADD;
         end
         OP_SW: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.mem_write = 1'b1;
            ctrl_o.alu_op    = ALU_ADD;
         end
         default: begin
            ctrl_o            = CTRL_NOP;
            ctrl_o.illegal_op = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/mips16_control_unit.sv
// ---------------------------------------------------------------------------
// mips16_control_unit
// Main control decoder with registered outputs (1-cycle latency, one opcode
// accepted per cycle, no handshake).
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset, clears every output
//   opcode     : 4-bit opcode, sampled on rising clk
//   reg_dest, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch,
//   alu_op[2:0], illegal_op : registered control outputs
// ---------------------------------------------------------------------------
module mips16_control_unit
   import mips16_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   output logic       reg_dest,
   output logic       alu_src,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       branch,
   output logic [2:0] alu_op,
   output logic       illegal_op
);

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;

   mips16_ctrl_decode u_decode (
      .opcode_i (opcode),
      .ctrl_o   (ctrl_d)
   );

   // Reset drops any in-flight decode immediately and holds the all-zero word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= CTRL_NOP;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign reg_dest   = ctrl_q.reg_dest;
   assign alu_src    = ctrl_q.alu_src;
   assign mem_to_reg = ctrl_q.mem_to_reg;
   assign reg_write  = ctrl_q.reg_write;
   assign mem_read   = ctrl_q.mem_read;
   assign mem_write  = ctrl_q.mem_write;
   assign branch     = ctrl_q.branch;
   assign alu_op     = ctrl_q.alu_op;
   assign illegal_op = ctrl_q.illegal_op;

endmodule

// File: tb/tb_mips16_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mips16_control_unit
// Scoreboard bench: the driver pushes the expected control word for every
// opcode it issues; a monitor pops one entry per clock and compares it with
// the registered DUT outputs. Reset behaviour is checked directly.
// Word layout: {reg_dest, alu_src, mem_to_reg, reg_write, mem_read,
//               mem_write, branch, alu_op[2:0], illegal_op}
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips16_control_unit;

   logic       clk;
   logic       rst;
   logic [3:0] opcode;
   logic       reg_dest, alu_src, mem_to_reg, reg_write;
   logic       mem_read, mem_write, branch, illegal_op;
   logic [2:0] alu_op;

   int errors = 0;
   int checks = 0;
   bit mon_en = 0;
   logic [10:0] sb[$];

   mips16_control_unit dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .reg_dest   (reg_dest),
      .alu_src    (alu_src),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .branch     (branch),
      .alu_op     (alu_op),
      .illegal_op (illegal_op)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [10:0] actual_word();
      return {reg_dest, alu_src, mem_to_reg, reg_write, mem_read,
              mem_write, branch, alu_op, illegal_op};
   endfunction

   // Reference model built from the instruction classes rather than a
   // per-opcode table.
   function automatic logic [10:0] model(input int op);
      logic rd, as, m2r, rw, mr, mw, br, ill;
      logic [2:0] aop;
      rd = 0; as = 0; m2r = 0; rw = 0; mr = 0; mw = 0; br = 0; ill = 0;
      aop = 3'd0;
      if (op > 9) begin
         ill = 1;
      end else begin
         br  = (op == 5) || (op == 6);
         rd  = (op == 0);
         as  = !rd && !br;                 // every I-type / memory op uses imm
         m2r = (op == 8);
         mr  = (op == 8);
         mw  = (op == 9);
         rw  = !br && !mw;
         aop = (op < 8) ? 3'(op) : 3'd1;   // memory ops compute an address
      end
      return {rd, as, m2r, rw, mr, mw, br, aop, ill};
   endfunction

   task automatic issue(input int op);
      @(negedge clk);
      opcode = 4'(op);
      sb.push_back(model(op));
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (actual_word() !== 11'd0) begin
         errors++;
         $display("FAIL %s: outputs=%b required=%b", name, actual_word(), 11'd0);
      end
   endtask

   // Monitor: one decoded word per clock while enabled.
   always @(posedge clk) begin
      #1;
      if (mon_en && sb.size() > 0) begin
         logic [10:0] exp_w, act_w;
         exp_w = sb.pop_front();
         act_w = actual_word();
         checks++;
         if (act_w !== exp_w) begin
            errors++;
            $display("FAIL decode: opcode_now=%b got=%b required=%b", opcode, act_w, exp_w);
         end else begin
            $display("txn ok: word=%b", act_w);
         end
         checks++;
         if ($isunknown(act_w) || (mem_read && mem_write) ||
             (branch && (reg_write || mem_write))) begin
            errors++;
            $display("FAIL invariant: got=%b required=no X, !(mr&mw), branch->!rw&!mw", act_w);
         end
      end
   end

   initial begin
      rst    = 1;
      opcode = 4'b1000;
      #2;
      check_zero("reset_initial");
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset_held");

      // Release and start the scoreboarded stream.
      @(negedge clk);
      rst    = 0;
      mon_en = 1;
      for (int i = 0; i < 16; i++) issue(i);   // full sweep incl. unused
      issue(1);                                 // legal after illegal
      issue(5);
      issue(6);
      for (int i = 0; i < 200; i++) issue(int'($urandom_range(0, 15)));

      // Leave a lw decode on the outputs, then reset mid-cycle.
      issue(8);
      @(posedge clk);
      #3;
      mon_en = 0;
      opcode = 4'b1000;
      rst    = 1;
      #1;
      check_zero("reset_async");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_zero("reset_hold_edges");
      end

      // First edge after release reflects the opcode sampled there.
      @(negedge clk);
      rst    = 0;
      mon_en = 1;
      opcode = 4'b1001;
      sb.push_back(model(9));
      for (int i = 0; i < 60; i++) issue(int'($urandom_range(0, 15)));

      @(posedge clk);
      #2;
      mon_en = 0;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: pending=%0d required=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
